enco_instr: RTL

- Pipelined RV32 instruction encoder. It is the inverse of the core's instruction decoder.
- Takes a decoded field set (12-bit internal code, rd/rs1/rs2, 32-bit immediate) and packs it into a 32-bit instruction word.
- Used by the debug/trace replay path and by the self-test micro-sequencer to inject instructions into fetch.
- Rejects field sets that cannot be encoded, flags them, and counts them.

---
 rtl/enco_pkg.sv | 49 ++++
 rtl/enco_imm_pack.sv | 57 +++++
 rtl/enco_instr.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/enco_pkg.sv
// Shared opcode, funct3 and operand-class definitions for the RV32 instruction encoder.
package enco_pkg;

    // Major opcodes (code[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IRQ    = 7'b0011000;

    localparam logic [11:0] CODE_ILL = 12'hFFF;

    // funct3 values, named after their ALU meaning
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRX  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Instruction layout class selected from the opcode
    typedef enum logic [3:0] {
        CL_U   = 4'd0,
        CL_J   = 4'd1,
        CL_I   = 4'd2,
        CL_B   = 4'd3,
        CL_S   = 4'd4,
        CL_SH  = 4'd5,
        CL_R   = 4'd6,
        CL_SYS = 4'd7,
        CL_ILL = 4'd8
    } cls_e;

    // True when v[31:k] all equal v[k-1], i.e. v fits a k-bit signed field
    function automatic logic sx_fit(input logic [31:0] v, input int unsigned k);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << (k - 1);
        return ((v & m) == 32'd0) || ((v & m) == m);
    endfunction

endpackage

// File: rtl/enco_imm_pack.sv
// Scatters the immediate into its instruction bit positions for the given
// layout class and flags immediates that are out of range or misaligned.
module enco_imm_pack
    import enco_pkg::*;
(
    input  cls_e        i_cls,
    input  logic [31:0] i_imm,
    output logic [31:0] o_imm_bits,
    output logic        o_imm_err
);

    // Per-class immediate placement and range/alignment check
    always_comb begin
        o_imm_bits = 32'd0;
        o_imm_err  = 1'b0;
        case (i_cls)
            CL_U: begin
                o_imm_bits = {i_imm[31:12], 12'd0};
                o_imm_err  = (i_imm[11:0] != 12'd0);
            end
            CL_J: begin
                o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'd0};
                o_imm_err  = i_imm[0] || !sx_fit(i_imm, 21);
            end
            CL_I: begin
                o_imm_bits = {i_imm[11:0], 20'd0};
                o_imm_err  = !sx_fit(i_imm, 12);
            end
            CL_B: begin
                o_imm_bits = {i_imm[12], i_imm[10:5], 13'd0, i_imm[4:1], i_imm[11], 7'd0};
                o_imm_err  = i_imm[0] || !sx_fit(i_imm, 13);
            end
            CL_S: begin
                o_imm_bits = {i_imm[11:5], 13'd0, i_imm[4:0], 7'd0};
                o_imm_err  = !sx_fit(i_imm, 12);
            end
            CL_SH: begin
                o_imm_bits = {7'd0, i_imm[4:0], 20'd0};
                o_imm_err  = (i_imm[31:5] != 27'd0);
            end
            CL_R: begin
                o_imm_bits = 32'd0;
                o_imm_err  = 1'b0;
            end
            CL_SYS: begin
                // CSR address is zero-extended, not sign-extended
                o_imm_bits = {i_imm[11:0], 20'd0};
                o_imm_err  = (i_imm[31:12] != 20'd0);
            end
            default: begin
                o_imm_bits = 32'd0;
                o_imm_err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/enco_instr.sv
// Two-stage RV32 instruction encoder: S1 holds the fields plus the code-level
// legality precheck, S2 holds the assembled word. Valid/ready on both sides.
module enco_instr
    import enco_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] ILL_INST = 32'hFFFF_FFFF
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      code,
    input  logic [4:0]       rdi,
    input  logic [4:0]       rs1i,
    input  logic [4:0]       rs2i,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic             w_s2_load;
    logic             w_s1_load;
    cls_e             w_cls;
    logic             w_pre_err;
    logic [2:0]       w_in_f3;

    logic             r_s1_valid;
    logic [11:0]      r_s1_code;
    logic [4:0]       r_s1_rd;
    logic [4:0]       r_s1_rs1;
    logic [4:0]       r_s1_rs2;
    logic [31:0]      r_s1_imm;
    cls_e             r_s1_cls;
    logic             r_s1_pre_err;

    logic [31:0]      w_imm_bits;
    logic             w_imm_err;
    logic [31:0]      w_base;
    logic [31:0]      w_inst;
    logic             w_err;
    logic [2:0]       w_f3;
    logic [6:0]       w_op;

    logic             r_out_valid;
    logic [31:0]      r_inst;
    logic             r_err;
    logic [CNT_W-1:0] r_enc_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    // A stage loads when empty or when its content is being taken downstream
    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    assign w_in_f3 = code[9:7];

    // Opcode class and code/register-level legality precheck on the input fields
    always_comb begin
        w_cls     = CL_ILL;
        w_pre_err = 1'b1;
        case (code[6:0])
            OP_LUI, OP_AUIPC: begin
                w_cls     = CL_U;
                w_pre_err = (code[11:7] != 5'd0);
            end
            OP_JAL: begin
                w_cls     = CL_J;
                w_pre_err = (code[11:7] != 5'd0);
            end
            OP_JALR: begin
                w_cls     = CL_I;
                w_pre_err = (w_in_f3 != F3_ADD);
            end
            OP_BRANCH: begin
                w_cls     = CL_B;
                w_pre_err = (w_in_f3 == F3_SLT) || (w_in_f3 == F3_SLTU);
            end
            OP_LOAD: begin
                w_cls     = CL_I;
                w_pre_err = (w_in_f3 == F3_SLTU) || (w_in_f3 == F3_OR) || (w_in_f3 == F3_AND);
            end
            OP_STORE: begin
                w_cls     = CL_S;
                w_pre_err = (w_in_f3 > F3_SLT);
            end
            OP_OPIMM: begin
                if ((w_in_f3 == F3_SLL) || (w_in_f3 == F3_SRX)) begin
                    w_cls     = CL_SH;
                    w_pre_err = (w_in_f3 == F3_SLL) && code[10];
                end else begin
                    w_cls     = CL_I;
                    w_pre_err = 1'b0;
                end
            end
            OP_OP: begin
                w_cls     = CL_R;
                w_pre_err = (code[11] && code[10]) ||
                            (code[10] && w_in_f3[2]) ||
                            (code[11] && !((w_in_f3 == F3_ADD) || (w_in_f3 == F3_SRX)));
            end
            OP_SYSTEM: begin
                w_cls     = CL_SYS;
                w_pre_err = (w_in_f3 == F3_XOR);
            end
            OP_IRQ: begin
                w_cls     = CL_I;
                w_pre_err = (w_in_f3 == F3_ADD) || (rs2i != imm[4:0]);
            end
            default: begin
                w_cls     = CL_ILL;
                w_pre_err = 1'b1;
            end
        endcase
    end

    // S1: capture fields, class and precheck on a transfer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid   <= 1'b0;
            r_s1_code    <= 12'd0;
            r_s1_rd      <= 5'd0;
            r_s1_rs1     <= 5'd0;
            r_s1_rs2     <= 5'd0;
            r_s1_imm     <= 32'd0;
            r_s1_cls     <= CL_ILL;
            r_s1_pre_err <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_code    <= code;
                r_s1_rd      <= rdi;
                r_s1_rs1     <= rs1i;
                r_s1_rs2     <= rs2i;
                r_s1_imm     <= imm;
                r_s1_cls     <= w_cls;
                r_s1_pre_err <= w_pre_err;
            end
        end
    end

    enco_imm_pack u_imm_pack (
        .i_cls      (r_s1_cls),
        .i_imm      (r_s1_imm),
        .o_imm_bits (w_imm_bits),
        .o_imm_err  (w_imm_err)
    );

    assign w_f3 = r_s1_code[9:7];
    assign w_op = r_s1_code[6:0];

    // Assemble register/funct fields around the scattered immediate
    always_comb begin
        w_base = 32'd0;
        case (r_s1_cls)
            CL_U, CL_J:   w_base = {20'd0, r_s1_rd, w_op};
            CL_I, CL_SYS: w_base = {12'd0, r_s1_rs1, w_f3, r_s1_rd, w_op};
            CL_B, CL_S:   w_base = {7'd0, r_s1_rs2, r_s1_rs1, w_f3, 5'd0, w_op};
            CL_SH:        w_base = {1'b0, r_s1_code[10], 5'd0, 5'd0, r_s1_rs1, w_f3, r_s1_rd, w_op};
            CL_R:         w_base = {1'b0, r_s1_code[11], 4'd0, r_s1_code[10], r_s1_rs2,
                                    r_s1_rs1, w_f3, r_s1_rd, w_op};
            default:      w_base = 32'd0;
        endcase
        w_err = r_s1_pre_err || w_imm_err;
        if (w_err) begin
            w_inst = ILL_INST;
        end else begin
            w_inst = w_base | w_imm_bits;
        end
    end

    // S2: register the assembled word; holds while the consumer stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_inst      <= 32'd0;
            r_err       <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_inst <= w_inst;
                r_err  <= w_err;
            end
        end
    end

    // Delivery counters, split by err, wrapping naturally
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_enc_cnt <= {CNT_W{1'b0}};
            r_err_cnt <= {CNT_W{1'b0}};
        end else if (r_out_valid && out_ready) begin
            if (r_err) begin
                r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_enc_cnt <= r_enc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid = r_out_valid;
    assign inst      = r_inst;
    assign err       = r_err;
    assign enc_cnt   = r_enc_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
